jtcop_sndcmd: RTL and testbench



---
 rtl/jtcop_sndcmd_mem.sv | 30 +++
 rtl/jtcop_sndcmd.sv | 123 ++++++++++++
 tb/tb_jtcop_sndcmd.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/jtcop_sndcmd_mem.sv
// Command queue storage: DEPTH x DW register array.
// One synchronous write port, one asynchronous read port, so the head of the
// queue is visible combinationally at the read pointer.
// Ports:
//   clk    - system clock
//   we     - write enable
//   waddr  - write address (write pointer)
//   wdata  - write data
//   raddr  - read address (read pointer)
//   rdata  - asynchronous read data
// Contents are not reset; the pointers and count in the parent decide what is valid.
module jtcop_sndcmd_mem #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] ram [2**AW];

  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
  end

  assign rdata = ram[raddr];
endmodule

// File: rtl/jtcop_sndcmd.sv
// Sound command queue between the main CPU and the sound CPU.
// Replaces the single sound latch + NMI flip-flop with a DEPTH-entry FIFO so
// back-to-back commands are kept. The NMI stays asserted while commands remain.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   snreq    - main-CPU command strobe (level); a rising edge pushes latch
//   latch    - command byte, sampled on the push cycle
//   sn_rd    - one-cycle pop strobe from the sound CPU
//   dout     - head-of-queue byte; last popped byte when empty
//   nmin     - active-low NMI to the sound CPU
//   empty    - queue empty
//   full     - queue full
//   count    - entries held, 0..DEPTH
//   ovf      - sticky overflow flag
//   ovf_clr  - clears ovf (a simultaneous new overflow wins)
// Parameters:
//   OVF_MODE 0: drop the new byte when full, 1: overwrite the oldest byte
//   NMI_MODE 0: level NMI, 1: NMI released for REARM cycles after each pop
//            that leaves commands pending, so an edge-triggered NMI re-fires
module jtcop_sndcmd #(
  parameter int DW       = 8,
  parameter int AW       = 2,
  parameter int OVF_MODE = 0,
  parameter int NMI_MODE = 0,
  parameter int REARM    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          snreq,
  input  logic [DW-1:0] latch,
  input  logic          sn_rd,
  output logic [DW-1:0] dout,
  output logic          nmin,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovf,
  input  logic          ovf_clr
);
  localparam int          DEPTH   = 2**AW;
  localparam int          RW      = 8;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [RW-1:0] REARM_C = RW'(REARM);
  localparam logic        OVW     = (OVF_MODE != 0);

  logic          snreq_l;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] last, head;
  logic [AW:0]   count_nxt;
  logic          push, pop, we, ovf_set, adv_rd;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign push    = snreq & ~snreq_l;
  assign pop     = sn_rd & ~empty;
  assign ovf_set = push & full & ~pop;
  // write unless the queue is full with no pop and we are in drop mode
  assign we      = push & (~full | pop | OVW);
  // in overwrite mode an overflow discards the oldest entry
  assign adv_rd  = pop | (ovf_set & OVW);
  assign dout    = empty ? last : head;

  always_comb begin
    count_nxt = count;
    if (push & ~full & ~pop)  count_nxt = count + 1'b1;
    else if (pop & ~push)     count_nxt = count - 1'b1;
  end

  jtcop_sndcmd_mem #(.DW(DW), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (latch),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      snreq_l <= 1'b1; // a strobe held through reset must not push
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      last    <= '0;
      ovf     <= 1'b0;
    end else begin
      snreq_l <= snreq;
      count   <= count_nxt;
      if (we)     wr_ptr <= wr_ptr + 1'b1;
      if (adv_rd) rd_ptr <= rd_ptr + 1'b1;
      if (pop)    last   <= head;
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  generate
    if (NMI_MODE == 0) begin : g_level
      always_ff @(posedge clk) begin
        if (rst) nmin <= 1'b1;
        else     nmin <= (count_nxt == '0);
      end
    end else begin : g_rearm
      logic [RW-1:0] rearm_cnt;
      always_ff @(posedge clk) begin
        if (rst) begin
          nmin      <= 1'b1;
          rearm_cnt <= '0;
        end else if (pop) begin
          // release NMI; if commands remain, re-assert after REARM cycles
          nmin      <= 1'b1;
          rearm_cnt <= (count_nxt != '0) ? REARM_C : '0;
        end else begin
          if (push & empty) nmin <= 1'b0;
          if (rearm_cnt != '0) begin
            rearm_cnt <= rearm_cnt - 1'b1;
            if (rearm_cnt == RW'(1)) nmin <= 1'b0;
          end
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_jtcop_sndcmd.sv
// Bench for jtcop_sndcmd. Three instances share one stimulus stream:
//   u0 default (drop on overflow, level NMI), u1 overwrite on overflow,
//   u2 re-armed NMI with REARM=4.
// A queue-based model predicts all outputs every cycle; a vector table and a
// hand-written NMI sequence add fixed expectations.
module tb_jtcop_sndcmd;
  localparam int DEPTH = 4;
  localparam int REARM = 4;

  logic clk = 1'b0;
  logic rst, snreq, sn_rd, ovf_clr;
  logic [7:0] latch;

  logic [7:0] dout0, dout1, dout2;
  logic nmin0, nmin1, nmin2, empty0, empty1, empty2, full0, full1, full2;
  logic ovf0, ovf1, ovf2;
  logic [2:0] count0, count1, count2;

  always #5 clk = ~clk;

  jtcop_sndcmd u0 (.clk(clk), .rst(rst), .snreq(snreq), .latch(latch), .sn_rd(sn_rd),
    .dout(dout0), .nmin(nmin0), .empty(empty0), .full(full0), .count(count0),
    .ovf(ovf0), .ovf_clr(ovf_clr));
  jtcop_sndcmd #(.OVF_MODE(1)) u1 (.clk(clk), .rst(rst), .snreq(snreq), .latch(latch),
    .sn_rd(sn_rd), .dout(dout1), .nmin(nmin1), .empty(empty1), .full(full1),
    .count(count1), .ovf(ovf1), .ovf_clr(ovf_clr));
  jtcop_sndcmd #(.NMI_MODE(1), .REARM(REARM)) u2 (.clk(clk), .rst(rst), .snreq(snreq),
    .latch(latch), .sn_rd(sn_rd), .dout(dout2), .nmin(nmin2), .empty(empty2),
    .full(full2), .count(count2), .ovf(ovf2), .ovf_clr(ovf_clr));

  int passed = 0, total = 0;

  // reference model state
  logic [7:0] qa[$];  // drop-on-full queue
  logic [7:0] qb[$];  // overwrite-oldest queue
  logic [7:0] lasta = 8'h00, lastb = 8'h00;
  logic ovf_m = 1'b0, snl_m = 1'b1;
  int cyc = 0, rel = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    else passed++;
  endtask

  // one clock: advance model from current inputs, then compare all instances
  task automatic step();
    logic push_m, pop_m, oset;
    logic [7:0] dummy;
    int sz, ecyc;
    ecyc   = cyc + 1;
    sz     = qa.size();
    push_m = snreq & ~snl_m;
    pop_m  = sn_rd & (sz != 0);
    if (rst) begin
      qa.delete(); qb.delete();
      lasta = 8'h00; lastb = 8'h00; ovf_m = 1'b0; snl_m = 1'b1; rel = 0;
    end else begin
      snl_m = snreq;
      oset  = push_m && sz == DEPTH && !pop_m;
      if (pop_m) begin lasta = qa.pop_front(); lastb = qb.pop_front(); end
      if (push_m) begin
        if (!oset) begin
          qa.push_back(latch); qb.push_back(latch);
          if (sz == 0) rel = 0;
        end else begin
          dummy = qb.pop_front();
          qb.push_back(latch);
        end
      end
      if (oset) ovf_m = 1'b1;
      else if (ovf_clr) ovf_m = 1'b0;
      if (pop_m && qa.size() != 0) rel = ecyc + REARM;
    end
    @(posedge clk); #1;
    cyc = ecyc;
    chk("d0.count", 32'(count0), 32'(qa.size()));
    chk("d0.dout",  32'(dout0), 32'(qa.size() != 0 ? qa[0] : lasta));
    chk("d0.empty", 32'(empty0), 32'(qa.size() == 0));
    chk("d0.full",  32'(full0), 32'(qa.size() == DEPTH));
    chk("d0.ovf",   32'(ovf0), 32'(ovf_m));
    chk("d0.nmin",  32'(nmin0), 32'(qa.size() == 0));
    chk("d1.count", 32'(count1), 32'(qb.size()));
    chk("d1.dout",  32'(dout1), 32'(qb.size() != 0 ? qb[0] : lastb));
    chk("d1.ovf",   32'(ovf1), 32'(ovf_m));
    chk("d2.dout",  32'(dout2), 32'(qa.size() != 0 ? qa[0] : lasta));
    chk("d2.nmin",  32'(nmin2), 32'(qa.size() == 0 ? 1 : (cyc < rel ? 1 : 0)));
  endtask

  task automatic drive(input logic s, input logic [7:0] l, input logic r,
                       input logic c, input logic rs);
    snreq = s; latch = l; sn_rd = r; ovf_clr = c; rst = rs;
  endtask

  typedef struct {
    logic       sn;
    logic [7:0] lat;
    logic       rd, clr, rs;
    logic [2:0] cnt;
    logic [7:0] d0, d1;
    logic       emp, fl, ov, n0;
  } vec_t;

  vec_t tbl[45];

  function automatic vec_t mk(logic sn, logic [7:0] lat, logic rd, logic clr, logic rs,
      logic [2:0] cnt, logic [7:0] d0, logic [7:0] d1, logic emp, logic fl, logic ov, logic n0);
    vec_t v;
    v.sn = sn; v.lat = lat; v.rd = rd; v.clr = clr; v.rs = rs;
    v.cnt = cnt; v.d0 = d0; v.d1 = d1; v.emp = emp; v.fl = fl; v.ov = ov; v.n0 = n0;
    return v;
  endfunction

  initial begin
    drive(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    //             sn lat    rd clr rs  cnt d0     d1     emp fl ov n0
    tbl[0]  = mk(1, 8'h00, 0, 0, 1,  0, 8'h00, 8'h00, 1, 0, 0, 1);
    tbl[1]  = mk(1, 8'h00, 0, 0, 1,  0, 8'h00, 8'h00, 1, 0, 0, 1);
    tbl[2]  = mk(1, 8'h5A, 0, 0, 0,  0, 8'h00, 8'h00, 1, 0, 0, 1);
    tbl[3]  = mk(0, 8'h00, 0, 0, 0,  0, 8'h00, 8'h00, 1, 0, 0, 1);
    tbl[4]  = mk(1, 8'h5A, 0, 0, 0,  1, 8'h5A, 8'h5A, 0, 0, 0, 0);
    tbl[5]  = mk(0, 8'h00, 1, 0, 0,  0, 8'h5A, 8'h5A, 1, 0, 0, 1);
    tbl[6]  = mk(1, 8'h11, 0, 0, 0,  1, 8'h11, 8'h11, 0, 0, 0, 0);
    tbl[7]  = mk(0, 8'h00, 0, 0, 0,  1, 8'h11, 8'h11, 0, 0, 0, 0);
    tbl[8]  = mk(1, 8'h22, 0, 0, 0,  2, 8'h11, 8'h11, 0, 0, 0, 0);
    tbl[9]  = mk(0, 8'h00, 0, 0, 0,  2, 8'h11, 8'h11, 0, 0, 0, 0);
    tbl[10] = mk(1, 8'h33, 0, 0, 0,  3, 8'h11, 8'h11, 0, 0, 0, 0);
    tbl[11] = mk(0, 8'h00, 1, 0, 0,  2, 8'h22, 8'h22, 0, 0, 0, 0);
    tbl[12] = mk(0, 8'h00, 1, 0, 0,  1, 8'h33, 8'h33, 0, 0, 0, 0);
    tbl[13] = mk(0, 8'h00, 1, 0, 0,  0, 8'h33, 8'h33, 1, 0, 0, 1);
    tbl[14] = mk(0, 8'h00, 1, 0, 0,  0, 8'h33, 8'h33, 1, 0, 0, 1);
    tbl[15] = mk(1, 8'hA1, 0, 0, 0,  1, 8'hA1, 8'hA1, 0, 0, 0, 0);
    tbl[16] = mk(0, 8'h00, 0, 0, 0,  1, 8'hA1, 8'hA1, 0, 0, 0, 0);
    tbl[17] = mk(1, 8'hA2, 0, 0, 0,  2, 8'hA1, 8'hA1, 0, 0, 0, 0);
    tbl[18] = mk(0, 8'h00, 0, 0, 0,  2, 8'hA1, 8'hA1, 0, 0, 0, 0);
    tbl[19] = mk(1, 8'hA3, 0, 0, 0,  3, 8'hA1, 8'hA1, 0, 0, 0, 0);
    tbl[20] = mk(0, 8'h00, 0, 0, 0,  3, 8'hA1, 8'hA1, 0, 0, 0, 0);
    tbl[21] = mk(1, 8'hA4, 0, 0, 0,  4, 8'hA1, 8'hA1, 0, 1, 0, 0);
    tbl[22] = mk(0, 8'h00, 0, 0, 0,  4, 8'hA1, 8'hA1, 0, 1, 0, 0);
    tbl[23] = mk(1, 8'hA5, 0, 0, 0,  4, 8'hA1, 8'hA2, 0, 1, 1, 0);
    tbl[24] = mk(0, 8'h00, 1, 0, 0,  3, 8'hA2, 8'hA3, 0, 0, 1, 0);
    tbl[25] = mk(0, 8'h00, 1, 0, 0,  2, 8'hA3, 8'hA4, 0, 0, 1, 0);
    tbl[26] = mk(0, 8'h00, 1, 0, 0,  1, 8'hA4, 8'hA5, 0, 0, 1, 0);
    tbl[27] = mk(0, 8'h00, 1, 0, 0,  0, 8'hA4, 8'hA5, 1, 0, 1, 1);
    tbl[28] = mk(0, 8'h00, 0, 1, 0,  0, 8'hA4, 8'hA5, 1, 0, 0, 1);
    tbl[29] = mk(1, 8'hB1, 0, 0, 0,  1, 8'hB1, 8'hB1, 0, 0, 0, 0);
    tbl[30] = mk(0, 8'h00, 0, 0, 0,  1, 8'hB1, 8'hB1, 0, 0, 0, 0);
    tbl[31] = mk(1, 8'hB2, 0, 0, 0,  2, 8'hB1, 8'hB1, 0, 0, 0, 0);
    tbl[32] = mk(0, 8'h00, 0, 0, 0,  2, 8'hB1, 8'hB1, 0, 0, 0, 0);
    tbl[33] = mk(1, 8'hB3, 0, 0, 0,  3, 8'hB1, 8'hB1, 0, 0, 0, 0);
    tbl[34] = mk(0, 8'h00, 0, 0, 0,  3, 8'hB1, 8'hB1, 0, 0, 0, 0);
    tbl[35] = mk(1, 8'hB4, 0, 0, 0,  4, 8'hB1, 8'hB1, 0, 1, 0, 0);
    tbl[36] = mk(0, 8'h00, 0, 0, 0,  4, 8'hB1, 8'hB1, 0, 1, 0, 0);
    tbl[37] = mk(1, 8'hB5, 1, 0, 0,  4, 8'hB2, 8'hB2, 0, 1, 0, 0);
    tbl[38] = mk(0, 8'h00, 0, 0, 0,  4, 8'hB2, 8'hB2, 0, 1, 0, 0);
    tbl[39] = mk(1, 8'hB6, 0, 0, 0,  4, 8'hB2, 8'hB3, 0, 1, 1, 0);
    tbl[40] = mk(0, 8'h00, 1, 0, 0,  3, 8'hB3, 8'hB4, 0, 0, 1, 0);
    tbl[41] = mk(0, 8'h00, 0, 0, 1,  0, 8'h00, 8'h00, 1, 0, 0, 1);
    tbl[42] = mk(0, 8'h00, 0, 0, 0,  0, 8'h00, 8'h00, 1, 0, 0, 1);
    tbl[43] = mk(1, 8'hC7, 0, 0, 0,  1, 8'hC7, 8'hC7, 0, 0, 0, 0);
    tbl[44] = mk(0, 8'h00, 0, 0, 0,  1, 8'hC7, 8'hC7, 0, 0, 0, 0);

    for (int i = 0; i < 45; i++) begin
      drive(tbl[i].sn, tbl[i].lat, tbl[i].rd, tbl[i].clr, tbl[i].rs);
      step();
      chk($sformatf("v%0d.count", i), 32'(count0), 32'(tbl[i].cnt));
      chk($sformatf("v%0d.dout",  i), 32'(dout0),  32'(tbl[i].d0));
      chk($sformatf("v%0d.dout1", i), 32'(dout1),  32'(tbl[i].d1));
      chk($sformatf("v%0d.empty", i), 32'(empty0), 32'(tbl[i].emp));
      chk($sformatf("v%0d.full",  i), 32'(full0),  32'(tbl[i].fl));
      chk($sformatf("v%0d.ovf",   i), 32'(ovf0),   32'(tbl[i].ov));
      chk($sformatf("v%0d.nmin",  i), 32'(nmin0),  32'(tbl[i].n0));
    end

    // re-armed NMI: queue holds C7, add D1, pop one -> nmin high exactly REARM cycles
    drive(1'b1, 8'hD1, 1'b0, 1'b0, 1'b0); step();
    chk("rearm.count2", 32'(count2), 32'd2);
    chk("rearm.nmin_pre", 32'(nmin2), 32'd0);
    drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); step();
    chk("rearm.hi0", 32'(nmin2), 32'd1);
    sn_rd = 1'b0;
    for (int k = 1; k < REARM; k++) begin
      step();
      chk($sformatf("rearm.hi%0d", k), 32'(nmin2), 32'd1);
    end
    step();
    chk("rearm.lo", 32'(nmin2), 32'd0);
    chk("rearm.dout", 32'(dout2), 32'hD1);
    sn_rd = 1'b1; step();
    chk("rearm.last", 32'(nmin2), 32'd1);
    sn_rd = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("rearm.stay%0d", k), 32'(nmin2), 32'd1);
    end

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 1) == 1), 8'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
